// File: rtl/instr_fetch.sv
// ============================================================================
// Module  : instr_fetch
// Purpose : Fetch stage; owns the PC and feeds decode with one word per cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        Freeze_IN,
  output logic        IMem_Req_OUT,
  output logic [31:0] IMem_Addr_OUT,
  input  logic [31:0] IMem_Data_IN,
  input  logic        IMem_Valid_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_busy, w_busy_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [31:0] r_buf_pc, w_buf_pc_nxt;
  logic [31:0] r_kill_addr, w_kill_addr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic [31:0] r_instr_pc4, w_instr_pc4_nxt;
  logic        w_req;
  logic        w_pending;

  always_comb begin
    w_req = 1'b0;
    case (r_state)
      ST_RUN:  w_req = r_busy | ~Freeze_IN;
      ST_KILL: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  // A request that is up this cycle and unanswered must be drained, even if
  // it was only raised this cycle, because the cache cannot abort it.
  assign w_pending = w_req & ~IMem_Valid_IN;

  assign IMem_Req_OUT       = w_req;
  assign IMem_Addr_OUT      = (r_state == ST_KILL) ? r_kill_addr : r_pc;
  assign Instr1_OUT         = r_instr;
  assign Instr_PC_OUT       = r_instr_pc;
  assign Instr_PC_Plus4_OUT = r_instr_pc4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_busy      <= 1'b0;
      r_buf       <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_kill_addr <= 32'd0;
      r_instr     <= 32'd0;
      r_instr_pc  <= 32'd0;
      r_instr_pc4 <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_busy      <= w_busy_nxt;
      r_buf       <= w_buf_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_kill_addr <= w_kill_addr_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_instr_pc4 <= w_instr_pc4_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_busy_nxt      = r_busy;
    w_buf_nxt       = r_buf;
    w_buf_pc_nxt    = r_buf_pc;
    w_kill_addr_nxt = r_kill_addr;
    w_instr_nxt     = r_instr;
    w_instr_pc_nxt  = r_instr_pc;
    w_instr_pc4_nxt = r_instr_pc4;

    if (Request_Alt_PC_IN) begin
      w_pc_nxt    = Alt_PC_IN;
      w_instr_nxt = 32'd0;
      if (w_pending) begin
        w_state_nxt = ST_KILL;
        w_busy_nxt  = 1'b1;
        // Re-redirects while draining keep the original drained address.
        if (r_state != ST_KILL)
          w_kill_addr_nxt = r_pc;
      end else begin
        w_state_nxt = ST_RUN;
        w_busy_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_req) begin
            if (IMem_Valid_IN) begin
              w_pc_nxt   = r_pc + 32'd4;
              w_busy_nxt = 1'b0;
              if (Freeze_IN) begin
                w_buf_nxt    = IMem_Data_IN;
                w_buf_pc_nxt = r_pc;
                w_state_nxt  = ST_HOLD;
              end else begin
                w_instr_nxt     = IMem_Data_IN;
                w_instr_pc_nxt  = r_pc;
                w_instr_pc4_nxt = r_pc + 32'd4;
              end
            end else begin
              w_busy_nxt = 1'b1;
              if (!Freeze_IN)
                w_instr_nxt = 32'd0;
            end
          end
        end
        ST_HOLD: begin
          if (!Freeze_IN) begin
            w_instr_nxt     = r_buf;
            w_instr_pc_nxt  = r_buf_pc;
            w_instr_pc4_nxt = r_buf_pc + 32'd4;
            w_state_nxt     = ST_RUN;
          end
        end
        ST_KILL: begin
          w_instr_nxt = 32'd0;
          if (IMem_Valid_IN) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module  : tb_instr_fetch
// Purpose : Random-stimulus scoreboard bench for instr_fetch.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] c_reset_pc = 32'h0040_0000;
  localparam logic [31:0] c_magic    = 32'h5A5A_5A5A;
  localparam int          c_cycles   = 600;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Alt_PC_IN = 32'd0;
  logic        Request_Alt_PC_IN = 1'b0;
  logic        Freeze_IN = 1'b0;
  logic        IMem_Req_OUT;
  logic [31:0] IMem_Addr_OUT;
  logic [31:0] IMem_Data_IN = 32'd0;
  logic        IMem_Valid_IN = 1'b0;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;

  instr_fetch #(.RESET_PC(c_reset_pc)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Alt_PC_IN          (Alt_PC_IN),
    .Request_Alt_PC_IN  (Request_Alt_PC_IN),
    .Freeze_IN          (Freeze_IN),
    .IMem_Req_OUT       (IMem_Req_OUT),
    .IMem_Addr_OUT      (IMem_Addr_OUT),
    .IMem_Data_IN       (IMem_Data_IN),
    .IMem_Valid_IN      (IMem_Valid_IN),
    .Instr1_OUT         (Instr1_OUT),
    .Instr_PC_OUT       (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        started  = 1'b0;
  int          edge_no  = 0;

  // Monitor: decode sees one output triple per edge; compare each against
  // the expectation queued by the stimulus side.
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge CLK);
      #2;
      edge_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Instr1_OUT !== e.instr || Instr_PC_OUT !== e.pc || Instr_PC_Plus4_OUT !== e.pc4) begin
          failures++;
          $display("FAIL decode_out edge=%0d got instr=%h pc=%h pc4=%h want instr=%h pc=%h pc4=%h",
                   edge_no, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, e.instr, e.pc, e.pc4);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    // Reference model: program-order stream, pending-delivery list, and a
    // cache model that tracks the single outstanding request.
    logic [31:0] fp;
    logic [31:0] pend[$];
    logic [31:0] p;
    exp_t        cur, e;
    logic        c_busy, c_stale, c_busy_after;
    logic [31:0] c_addr;
    int          c_left, lat;
    logic        frz, redir, v, force_hit;
    logic [31:0] alt;

    #1 RESET = 1'b0;
    #2;
    check("reset_instr", Instr1_OUT, 32'd0);
    check("reset_pc", Instr_PC_OUT, 32'd0);
    check("reset_pc4", Instr_PC_Plus4_OUT, 32'd0);
    check("reset_req", {31'd0, IMem_Req_OUT}, 32'd1);
    check("reset_addr", IMem_Addr_OUT, c_reset_pc);
    Freeze_IN = 1'b1;
    #1;
    check("reset_req_frozen", {31'd0, IMem_Req_OUT}, 32'd0);
    Freeze_IN = 1'b0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET   = 1'b1;
    started = 1'b1;

    fp      = c_reset_pc;
    cur     = '0;
    c_busy  = 1'b0;
    c_stale = 1'b0;
    c_addr  = 32'd0;
    c_left  = 0;
    frz     = 1'b0;

    for (int cyc = 0; cyc < c_cycles; cyc++) begin
      force_hit = (cyc < 12) || (cyc >= 300 && cyc < 320);
      redir     = 1'b0;
      alt       = 32'd0;
      if (force_hit) begin
        frz = 1'b0;
        if (cyc == 300) begin
          redir = 1'b1;
          alt   = 32'hFFFF_FFFC;
        end
      end else begin
        frz = frz ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 99) < 15);
        if ($urandom_range(0, 99) < 8) begin
          redir = 1'b1;
          alt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
        end
      end
      Freeze_IN         = frz;
      Request_Alt_PC_IN = redir;
      Alt_PC_IN         = redir ? alt : $urandom();
      #1;

      v = 1'b0;
      if (c_busy) check("req_held", {31'd0, IMem_Req_OUT}, 32'd1);
      if (IMem_Req_OUT) begin
        if (!c_busy) begin
          check("new_req_addr", IMem_Addr_OUT, fp);
          check("new_req_unfrozen", {31'd0, frz}, 32'd0);
          lat    = force_hit ? 0 : (($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4));
          c_addr = IMem_Addr_OUT;
          c_left = lat;
        end else begin
          check("addr_stable", IMem_Addr_OUT, c_addr);
        end
        if (c_left == 0) v = 1'b1;
        else c_left--;
      end
      c_busy_after  = IMem_Req_OUT && !v;
      IMem_Valid_IN = v;
      IMem_Data_IN  = v ? (c_addr ^ c_magic) : $urandom();

      e = cur;
      if (redir) begin
        e.instr = 32'd0;
        pend.delete();
        fp      = alt;
        c_stale = c_busy_after;
      end else begin
        if (v) begin
          if (c_stale) c_stale = 1'b0;
          else begin
            pend.push_back(fp);
            fp = fp + 32'd4;
          end
        end
        if (!frz && pend.size() > 0) begin
          p       = pend.pop_front();
          e.instr = p ^ c_magic;
          e.pc    = p;
          e.pc4   = p + 32'd4;
        end else if (!frz) begin
          e.instr = 32'd0;
        end
      end
      cur = e;
      exp_q.push_back(e);
      c_busy = c_busy_after;

      @(negedge CLK);
    end

    Freeze_IN         = 1'b0;
    Request_Alt_PC_IN = 1'b0;
    IMem_Valid_IN     = 1'b0;
    started           = 1'b0;
    @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
